// File: rtl/dmem_ctrl.sv
// Word-organised data memory behind the MEM stage, with a fixed multi-cycle
// access latency and busy/done/error status for the pipeline.
module dmem_ctrl #(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 2,
   parameter int unsigned CNT_W   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  proc2Dmem_command,
   input  logic [31:0] proc2Dmem_addr,
   input  logic [31:0] proc2mem_data,
   output logic [31:0] mem2proc_data,
   output logic        mem2proc_done,
   output logic        mem2proc_err,
   output logic        dmem_busy
);

   localparam int unsigned AW = $clog2(DEPTH);

   localparam logic [1:0] BUS_NONE  = 2'h0;
   localparam logic [1:0] BUS_LOAD  = 2'h1;
   localparam logic [1:0] BUS_STORE = 2'h2;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       cmd_q;
   logic [31:0]      addr_q;
   logic [31:0]      data_q;

   logic [31:0]      mem [DEPTH];

   logic [AW-1:0]    word_idx;
   logic             bad_addr;
   logic             accept;
   logic             complete;

   assign word_idx  = addr_q[AW+1:2];
   assign bad_addr  = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);
   assign accept    = ((state == IDLE) || (state == RESP)) && (proc2Dmem_command != BUS_NONE);
   assign complete  = (state == WAIT) && (cnt == '0);
   assign dmem_busy = (state == WAIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         cmd_q         <= BUS_NONE;
         addr_q        <= '0;
         data_q        <= '0;
         mem2proc_data <= '0;
         mem2proc_done <= 1'b0;
         mem2proc_err  <= 1'b0;
      end else begin
         mem2proc_done <= 1'b0;
         mem2proc_err  <= 1'b0;
         case (state)
            IDLE, RESP: begin
               if (accept) begin
                  state  <= WAIT;
                  cnt    <= CNT_W'(LATENCY - 1);
                  cmd_q  <= proc2Dmem_command;
                  addr_q <= proc2Dmem_addr;
                  data_q <= proc2mem_data;
               end else begin
                  state <= IDLE;
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  state         <= RESP;
                  mem2proc_done <= 1'b1;
                  mem2proc_err  <= bad_addr;
                  if (cmd_q == BUS_LOAD) begin
                     mem2proc_data <= bad_addr ? 32'h0 : mem[word_idx];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Storage is deliberately outside the reset domain; contents survive rst.
   always_ff @(posedge clk) begin
      if (complete && (cmd_q == BUS_STORE) && !bad_addr) begin
         mem[word_idx] <= data_q;
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a timing/transaction model predicts every
// output each cycle, plus literal checks on key results.
module tb_dmem_ctrl;

   localparam int unsigned DEPTH   = 1024;
   localparam int unsigned LATENCY = 2;
   localparam int unsigned CNT_W   = 4;

   localparam logic [1:0] BUS_NONE  = 2'h0;
   localparam logic [1:0] BUS_LOAD  = 2'h1;
   localparam logic [1:0] BUS_STORE = 2'h2;

   logic        clk;
   logic        rst;
   logic [1:0]  cmd;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        done;
   logic        err;
   logic        busy;

   int n_cmp  = 0;
   int n_fail = 0;

   dmem_ctrl #(
      .DEPTH   (DEPTH),
      .LATENCY (LATENCY),
      .CNT_W   (CNT_W)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .proc2Dmem_command (cmd),
      .proc2Dmem_addr    (addr),
      .proc2mem_data     (wdata),
      .mem2proc_data     (rdata),
      .mem2proc_done     (done),
      .mem2proc_err      (err),
      .dmem_busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: an access accepted at edge e completes at edge e+LATENCY,
   // and the next command can be taken from edge e+LATENCY+1 on.
   logic [31:0] mdl_mem [int];
   int unsigned edge_n, due, next_free;
   bit          pend;
   logic [1:0]  p_cmd;
   logic [31:0] p_addr, p_data;
   logic        m_done, m_err, m_busy;
   logic [31:0] m_data;
   bit          bad;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pend = 0; next_free = 0; edge_n = 0;
         m_done = 0; m_err = 0; m_busy = 0; m_data = 0;
      end else begin
         edge_n++;
         m_done = 0;
         m_err  = 0;
         if (pend && edge_n == due) begin
            bad    = (p_addr % 4 != 0) || (p_addr >= DEPTH * 4);
            m_done = 1;
            m_err  = bad;
            if (p_cmd == BUS_LOAD)
               m_data = bad ? 32'h0 : (mdl_mem.exists(int'(p_addr / 4)) ? mdl_mem[int'(p_addr / 4)] : 32'h0);
            else if (p_cmd == BUS_STORE && !bad)
               mdl_mem[int'(p_addr / 4)] = p_data;
            pend = 0;
         end
         if (edge_n >= next_free && cmd != BUS_NONE) begin
            pend = 1; due = edge_n + LATENCY; next_free = due + 1;
            p_cmd = cmd; p_addr = addr; p_data = wdata;
         end
         m_busy = pend && (edge_n < due);
      end
   end

   always @(posedge clk) begin
      #1;
      if (!rst) begin
         check("model done", {31'h0, done}, {31'h0, m_done});
         check("model err",  {31'h0, err},  {31'h0, m_err});
         check("model busy", {31'h0, busy}, {31'h0, m_busy});
         check("model data", rdata, m_data);
      end
   end

   task automatic timeout(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got timeout expected event at %0t", name, $time);
   endtask

   // Present a command, hold while busy, drop it after the accepting edge.
   task automatic issue(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
      int n = 0;
      @(negedge clk);
      cmd = c; addr = a; wdata = d;
      while (busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (busy) timeout("issue");
      @(negedge clk);
      cmd = BUS_NONE;
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 20);
      if (!done) timeout("wait_done");
   endtask

   int dones;

   initial begin
      rst = 1'b1; cmd = BUS_NONE; addr = '0; wdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle data", rdata, 32'h0);
         check("idle done", {31'h0, done}, 32'h0);
         check("idle err",  {31'h0, err},  32'h0);
         check("idle busy", {31'h0, busy}, 32'h0);
      end

      issue(BUS_STORE, 32'h40, 32'hDEADBEEF);
      wait_done();
      check("store err", {31'h0, err}, 32'h0);
      check("store keeps data", rdata, 32'h0);
      issue(BUS_LOAD, 32'h40, 32'h0);
      wait_done();
      check("load 0x40", rdata, 32'hDEADBEEF);
      check("load err", {31'h0, err}, 32'h0);

      // Held load from the RESP cycle: done every LATENCY+1 cycles.
      cmd = BUS_LOAD; addr = 32'h40;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      cmd = BUS_NONE;
      check("b2b done count", dones, 32'd4);
      check("b2b data", rdata, 32'hDEADBEEF);
      repeat (3) @(negedge clk);

      issue(BUS_LOAD, 32'h42, 32'h0);
      wait_done();
      check("misaligned err", {31'h0, err}, 32'h1);
      check("misaligned data", rdata, 32'h0);
      issue(BUS_LOAD, 32'h1000, 32'h0);
      wait_done();
      check("range err", {31'h0, err}, 32'h1);
      check("range data", rdata, 32'h0);
      issue(BUS_LOAD, 32'h40, 32'h0);
      wait_done();
      check("reload 0x40", rdata, 32'hDEADBEEF);
      check("reload err", {31'h0, err}, 32'h0);

      issue(BUS_STORE, 32'h48, 32'hA5A50048);
      wait_done();
      issue(BUS_STORE, 32'h50, 32'h0BAD0050);
      wait_done();

      // Inputs change while the store to 0x44 is outstanding.
      issue(BUS_STORE, 32'h44, 32'h1);
      cmd = BUS_STORE; addr = 32'h48; wdata = 32'h2;
      @(negedge clk);
      cmd = BUS_NONE;
      @(negedge clk);
      check("chg done", {31'h0, done}, 32'h1);
      issue(BUS_LOAD, 32'h48, 32'h0);
      wait_done();
      check("load 0x48", rdata, 32'hA5A50048);
      issue(BUS_LOAD, 32'h44, 32'h0);
      wait_done();
      check("load 0x44", rdata, 32'h1);

      // Reset lands while the store to 0x50 is waiting.
      issue(BUS_STORE, 32'h50, 32'h55);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("post-rst data", rdata, 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post-rst done", {31'h0, done}, 32'h0);
      end
      issue(BUS_LOAD, 32'h50, 32'h0);
      wait_done();
      check("load 0x50", rdata, 32'h0BAD0050);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got hang expected finish");
      $fatal(1);
   end

endmodule
